wb_stage: RTL
=============

Name: wb_stage

Overview:
- Final (writeback) pipeline stage, directly downstream of the memory stage.
- Latches the memory stage's 188-bit payload and 47-bit exception payload, then commits register-file and CSR writes.
- Sequences TLB and CACOP side operations through a request/ack handshake.
- Raises the pipeline-wide flush for exceptions, ertn, and refetch-after-CSR/TLB writes; drives the debug trace port.

Parameters:
- ZIP_W, 188, width of MEM_to_WB_zip
- EXC_W, 15, width of the exception vector within MEM_except_zip

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- WB_allowin  out  1  stage can accept a new instruction this cycle
- MEM_to_WB  in  1  transfer strobe from the memory stage
- MEM_to_WB_zip  in  188  {valid,pc[32],IR[32],gr_we,rf_waddr[5],rf_wdata[32],tlbrd,tlbwr,tlbfill,invtlb,cacop,csr_re,csr_we,csr_wmask[32],csr_wvalue[32],csr_num[14]}, MSB first
- MEM_except_zip  in  47  {exc[14:0],badv[31:0]}; exc[14]=ertn, exc[13:0]=exception flags (bit 0 highest priority)
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- csr_num  out  14  CSR index (read and write)
- csr_rvalue  in  32  combinational CSR read data for csr_num
- csr_we  out  1  CSR write strobe
- csr_wmask  out  32  CSR write mask
- csr_wvalue  out  32  CSR write value
- op_req  out  1  TLB/CACOP request, level, held until ack
- op_type  out  5  {tlbrd,tlbwr,tlbfill,invtlb,cacop}, exactly one bit set while op_req
- op_ack  in  1  side-operation completion, single cycle
- wb_ex  out  1  exception commit pulse
- wb_exc  out  14  exception flags to the CSR unit
- wb_badv  out  32  faulting address
- wb_pc  out  32  pc of the committing instruction
- ertn_flush  out  1  ertn commit pulse
- flush  out  1  pipeline flush pulse
- refetch_pc  out  32  pc+4, valid with a refetch flush
- front_valid  out  1  forwarding: WB will write the register file
- front_addr  out  5  forwarding address
- front_data  out  32  forwarding data
- WB_is_csr  out  1  valid instruction in WB with csr_re or csr_we
- debug_wb_pc  out  32  trace pc
- debug_wb_rf_we  out  4  trace write strobe
- debug_wb_rf_wnum  out  5  trace write register
- debug_wb_rf_wdata  out  32  trace write data

Behaviour:
- Reset (rst==0 at posedge) clears:
  - the payload registers;
  - state to IDLE;
  - every output, except WB_allowin, which reads 1.
- Capture:
  - Payload registers load when MEM_to_WB & ~flush.
  - A MEM_to_WB arriving in the same cycle as flush is dropped.
- valid = state!=IDLE & payload valid bit.
- States:
  - IDLE: no instruction. WB_allowin=1. Goes to EXEC on capture.
  - EXEC: one cycle; decides the instruction's path:
    - exc!=0: commit as exception. No rf_we, csr_we, or op_req. Pulse wb_ex (exc[13:0]!=0) or ertn_flush (exc==ertn only), plus flush. Next state IDLE.
    - any op bit set: assert op_req. Next state WAIT. rf_we and csr_we held low.
    - otherwise: commit this cycle. rf_we=gr_we and csr_we=csr_we. flush when csr_we=1, with refetch_pc=pc+4. Next state EXEC on a new capture, else IDLE.
  - WAIT: op_req and op_type held stable until op_ack.
    - On op_ack, in the same cycle: commit (rf_we=gr_we), drop op_req, pulse flush with refetch_pc=pc+4.
    - invtlb and cacop do not refetch: no flush for them.
    - Next state IDLE.
- WB_allowin = IDLE | (EXEC & normal commit & ~flush) | (WAIT & op_ack & ~flush).
  - Back-to-back plain instructions commit at 1 per cycle.
- rf_wdata = csr_re ? csr_rvalue : payload rf_wdata.
- csr_num, csr_wmask and csr_wvalue come straight from the payload.
- Forwarding:
  - front_valid = valid & gr_we & exc==0.
  - front_data equals rf_wdata.
  - In WAIT, front_valid stays 1, so the ID stage stalls on a dependency.
- Trace: debug_wb_rf_we = {4{rf_we}}; debug_wb_pc = pc whenever a commit or exception occurs.
- The flush output is registered only through state; it asserts for exactly one cycle per event.
- op_ack while not in WAIT is ignored.
- Reset asserted while in WAIT: return to IDLE immediately, drop op_req, no commit.

Test Plan:
- Two plain ALU instructions back-to-back (gr_we=1, waddr=5/6, wdata=0x11/0x22) -> rf_we high on consecutive cycles with matching addr/data; WB_allowin stays 1.
- csr_re=1, csr_num=0x0C, csr_rvalue=0xDEADBEEF, waddr=4 -> rf_wdata=0xDEADBEEF; WB_is_csr=1; no flush.
- csr_we=1, pc=0x1C000100 -> csr_we pulse, flush pulse, refetch_pc=0x1C000104.
- tlbwr, op_ack held off 3 cycles -> op_req=1 with op_type=5'b01000 for 4 cycles; WB_allowin=0 until the ack cycle; flush with refetch_pc=pc+4 on the ack cycle.
- exc=15'h0004, badv=0x80000003 -> wb_ex pulse, wb_exc=14'h0004, wb_badv=0x80000003, flush; no rf_we; a same-cycle MEM_to_WB is not captured.
- rst driven low while in WAIT -> next cycle op_req=0, state IDLE, no commit; a late op_ack is ignored.

Source files
------------

// File: rtl/wb_stage_if.sv
// wb_stage_if: memory-stage payload handshake and TLB/CACOP side-operation handshake
interface wb_stage_if #(parameter int ZIP_W = 188, parameter int EXC_W = 15);
  logic             WB_allowin;
  logic             MEM_to_WB;
  logic [ZIP_W-1:0] MEM_to_WB_zip;
  logic [EXC_W+31:0] MEM_except_zip;
  logic             op_req;
  logic [4:0]       op_type;
  logic             op_ack;
  modport master(input WB_allowin, op_req, op_type, output MEM_to_WB, MEM_to_WB_zip, MEM_except_zip, op_ack);
  modport slave(output WB_allowin, op_req, op_type, input MEM_to_WB, MEM_to_WB_zip, MEM_except_zip, op_ack);
endinterface

// File: rtl/wb_stage.sv
// wb_stage: writeback stage committing RF/CSR writes, sequencing TLB/CACOP ops and raising flushes
module wb_stage #(parameter int ZIP_W = 188, parameter int EXC_W = 15) (
  input  logic        clk,
  input  logic        rst,
  wb_stage_if.slave   bus,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [13:0] csr_num,
  input  logic [31:0] csr_rvalue,
  output logic        csr_we,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  output logic        wb_ex,
  output logic [13:0] wb_exc,
  output logic [31:0] wb_badv,
  output logic [31:0] wb_pc,
  output logic        ertn_flush,
  output logic        flush,
  output logic [31:0] refetch_pc,
  output logic        front_valid,
  output logic [4:0]  front_addr,
  output logic [31:0] front_data,
  output logic        WB_is_csr,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_we,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);
  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        gr_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  op;
    logic        csr_re;
    logic        csr_we;
    logic [31:0] wmask;
    logic [31:0] wvalue;
    logic [13:0] num;
  } zip_t;
  typedef enum logic [1:0] {IDLE, EXEC, WAIT} state_t;
  state_t            state_q, state_d;
  zip_t              p_q;
  logic [EXC_W+31:0] ex_q;
  logic [EXC_W-1:0]  exc;
  logic valid, in_idle, in_exec, in_wait, has_exc, has_op, norm, ack, commit, ex_commit, refetch, cap;
  logic unused_ir;
  assign unused_ir = ^p_q.ir;
  assign exc       = ex_q[EXC_W+31:32];
  assign in_idle   = state_q == IDLE;
  assign in_exec   = state_q == EXEC;
  assign in_wait   = state_q == WAIT;
  assign valid     = !in_idle && p_q.v;
  assign has_exc   = valid && |exc;
  assign has_op    = valid && |p_q.op && !has_exc;
  assign norm      = in_exec && !has_exc && !has_op;
  assign ack       = in_wait && bus.op_ack && rst;
  assign commit    = (norm && valid) || ack;
  assign ex_commit = in_exec && has_exc;
  // invtlb/cacop leave fetched instructions valid; only TLB state reads/writes refetch
  assign refetch   = (norm && valid && p_q.csr_we) || (ack && |p_q.op[4:2]);
  assign flush     = ex_commit || refetch;
  assign bus.WB_allowin = in_idle || ((norm || ack) && !flush);
  assign cap       = bus.MEM_to_WB && bus.WB_allowin;
  assign bus.op_req  = (in_exec && has_op) || (in_wait && !bus.op_ack);
  assign bus.op_type = bus.op_req ? p_q.op : 5'b0;
  assign rf_we       = commit && p_q.gr_we;
  assign rf_waddr    = p_q.waddr;
  assign rf_wdata    = p_q.csr_re ? csr_rvalue : p_q.wdata;
  assign csr_num     = p_q.num;
  assign csr_we      = norm && valid && p_q.csr_we;
  assign csr_wmask   = p_q.wmask;
  assign csr_wvalue  = p_q.wvalue;
  assign wb_ex       = ex_commit && |exc[EXC_W-2:0];
  assign ertn_flush  = ex_commit && !(|exc[EXC_W-2:0]);
  assign wb_exc      = ex_commit ? exc[EXC_W-2:0] : 14'b0;
  assign wb_badv     = ex_commit ? ex_q[31:0] : 32'b0;
  assign wb_pc       = (commit || ex_commit) ? p_q.pc : 32'b0;
  assign refetch_pc  = refetch ? p_q.pc + 32'd4 : 32'b0;
  assign front_valid = valid && p_q.gr_we && !(|exc);
  assign front_addr  = rf_waddr;
  assign front_data  = rf_wdata;
  assign WB_is_csr   = valid && (p_q.csr_re || p_q.csr_we);
  assign debug_wb_pc       = wb_pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
  always_comb begin
    state_d = cap ? EXEC : IDLE;
    if (in_exec && has_op) state_d = WAIT;
    if (in_wait && !ack) state_d = WAIT;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      ex_q    <= '0;
    end else begin
      state_q <= state_d;
      if (cap) begin
        p_q  <= zip_t'(bus.MEM_to_WB_zip);
        ex_q <= bus.MEM_except_zip;
      end
    end
  end
endmodule
